// File: rtl/adpcma_rom_bus_master.sv
// -----------------------------------------------------------------------------
// adpcma_rom_bus_master
//
// Sound-chip-side initiator for the cartridge ADPCM-A ROM bus. A 24-bit byte
// address from the ADPCM-A fetch logic is time-multiplexed onto SDRAD/SDRA_L/
// SDRA_U in two phases. The SDRMPX rising edge latches phase 1 in the
// cartridge and the falling edge latches phase 2. The master then releases
// SDRAD, pulls nSDROE low and samples the returned ROM byte.
//
// Ports
//   CLK     in   system clock, rising edge
//   RESET   in   asynchronous, active-high reset
//   REQ     in   read request, accepted only while idle
//   ADDR    in   [23:0] ROM byte address, captured on the accepting edge
//   BUSY    out  transaction in progress
//   DVALID  out  one-cycle pulse, DOUT holds new data
//   DOUT    out  [7:0] returned ROM byte, held until the next DVALID
//   SDRAD   io   [7:0] multiplexed address out / data in
//   SDRA_L  out  [1:0] A[9:8] in phase 1, A[19:18] in phase 2
//   SDRA_U  out  [3:0] A[23:20] in phase 2
//   SDRMPX  out  address phase strobe
//   nSDROE  out  ROM output enable, active low
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus parked, waiting for REQ
// LO_SETUP | drive A[9:0] ahead of the SDRMPX rising edge
// LO_HOLD  | SDRMPX high, phase-1 address held
// HI_SETUP | drive A[23:10] ahead of the SDRMPX falling edge
// HI_HOLD  | SDRMPX low, phase-2 address held
// TURN     | SDRAD released, nSDROE still high
// READ     | nSDROE low while the ROM drives SDRAD
//
// Every bus output is loaded from the current state, so the pins trail the
// state register by one cycle. This gives exactly SETUP/HOLD/WAIT cycles for
// each window. The ROM byte is sampled on the edge that ends the nSDROE-low
// window, one edge after the FSM has already returned to IDLE, which is what
// lets a request held high be accepted on that same edge.
// -----------------------------------------------------------------------------
module adpcma_rom_bus_master #(
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned HOLD_CYC  = 1,
   parameter int unsigned WAIT_CYC  = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ,
   input  logic [23:0] ADDR,
   output logic        BUSY,
   output logic        DVALID,
   output logic [7:0]  DOUT,
   inout  wire  [7:0]  SDRAD,
   output logic [1:0]  SDRA_L,
   output logic [3:0]  SDRA_U,
   output logic        SDRMPX,
   output logic        nSDROE
);

   localparam int CW = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO_SETUP,
      S_LO_HOLD,
      S_HI_SETUP,
      S_HI_HOLD,
      S_TURN,
      S_READ
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [23:0]     a_q;
   logic [7:0]      ad_out_q;
   logic            ad_oe_q;
   logic [1:0]      sdra_l_q;
   logic [3:0]      sdra_u_q;
   logic            mpx_q;
   logic            noe_q;
   logic            busy_q;
   logic            dvalid_q;
   logic [7:0]      dout_q;
   logic            smp_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         ad_out_q <= '0;
         ad_oe_q  <= 1'b0;
         sdra_l_q <= '0;
         sdra_u_q <= '0;
         mpx_q    <= 1'b0;
         noe_q    <= 1'b1;
         busy_q   <= 1'b0;
         dvalid_q <= 1'b0;
         dout_q   <= '0;
         smp_q    <= 1'b0;
      end else begin
         dvalid_q <= 1'b0;
         smp_q    <= 1'b0;

         // Closes the nSDROE window of the transaction that just left READ.
         if (smp_q) begin
            dout_q   <= SDRAD;
            dvalid_q <= 1'b1;
            noe_q    <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (REQ) begin
                  a_q     <= ADDR;
                  cnt_q   <= CW'(SETUP_CYC - 1);
                  busy_q  <= 1'b1;
                  state_q <= S_LO_SETUP;
               end
            end

            S_LO_SETUP: begin
               ad_oe_q  <= 1'b1;
               ad_out_q <= a_q[7:0];
               sdra_l_q <= a_q[9:8];
               mpx_q    <= 1'b0;
               if (cnt_q == '0) begin
                  cnt_q   <= CW'(HOLD_CYC - 1);
                  state_q <= S_LO_HOLD;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_LO_HOLD: begin
               mpx_q <= 1'b1;
               if (cnt_q == '0) begin
                  cnt_q   <= CW'(SETUP_CYC - 1);
                  state_q <= S_HI_SETUP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_HI_SETUP: begin
               ad_out_q <= a_q[17:10];
               sdra_l_q <= a_q[19:18];
               sdra_u_q <= a_q[23:20];
               mpx_q    <= 1'b1;
               if (cnt_q == '0) begin
                  cnt_q   <= CW'(HOLD_CYC - 1);
                  state_q <= S_HI_HOLD;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_HI_HOLD: begin
               mpx_q <= 1'b0;
               if (cnt_q == '0) begin
                  state_q <= S_TURN;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            // Release SDRAD a full cycle before nSDROE falls so the two
            // drivers never overlap on the bus.
            S_TURN: begin
               ad_oe_q <= 1'b0;
               cnt_q   <= CW'(WAIT_CYC - 1);
               state_q <= S_READ;
            end

            S_READ: begin
               noe_q <= 1'b0;
               if (cnt_q == '0) begin
                  busy_q  <= 1'b0;
                  smp_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign SDRAD  = ad_oe_q ? ad_out_q : 8'hzz;
   assign SDRA_L = sdra_l_q;
   assign SDRA_U = sdra_u_q;
   assign SDRMPX = mpx_q;
   assign nSDROE = noe_q;
   assign BUSY   = busy_q;
   assign DVALID = dvalid_q;
   assign DOUT   = dout_q;

endmodule
